// File: rtl/dpi_pkg.sv
// Shared types and default widths for the DPI matcher feeder and its context store.
package dpi_pkg;

    localparam int unsigned DPI_FLOW_BITS = 4;
    localparam int unsigned DPI_STATE_W   = 11;
    localparam int unsigned DPI_OFS_W     = 16;

    typedef logic [DPI_FLOW_BITS-1:0] flow_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        SAVE   = 2'd3
    } feed_state_t;

endpackage

// File: rtl/dpi_ctx_ram.sv
// Per-flow DFA context register file: one async read port, one write port,
// and a clear port that takes priority over a write to the same entry.
module dpi_ctx_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clr_en && (clr_addr == ADDR_W'(i))) begin
                    mem[i] <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dpi_flow_feeder.sv
// Restores a flow's DFA state into the matcher, streams the payload, reports
// matches with flow/offset, and saves the matcher's final state at end of packet.
module dpi_flow_feeder
    import dpi_pkg::*;
#(
    parameter int unsigned FLOW_BITS = DPI_FLOW_BITS,
    parameter int unsigned STATE_W   = DPI_STATE_W,
    parameter int unsigned OFS_W     = DPI_OFS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    output logic                 pkt_ready,
    input  logic [7:0]           pkt_data,
    input  logic                 pkt_sop,
    input  logic                 pkt_eop,
    input  logic [FLOW_BITS-1:0] pkt_flow,
    input  logic                 flow_clr,
    input  logic [FLOW_BITS-1:0] flow_clr_id,
    output logic [7:0]           char_out,
    output logic                 char_out_vld,
    output logic [STATE_W-1:0]   state_load,
    output logic                 state_load_vld,
    input  logic [STATE_W-1:0]   state_cur,
    input  logic                 accept_in,
    output logic                 match_vld,
    output logic [FLOW_BITS-1:0] match_flow,
    output logic [OFS_W-1:0]     match_offset,
    output logic                 proto_err
);

    localparam logic [OFS_W-1:0] OFS_MAX = '1;

    feed_state_t          state_q;
    feed_state_t          state_d;
    logic [FLOW_BITS-1:0] cur_flow_q;
    logic                 first_q;
    logic                 pend_clr_q;
    logic [OFS_W-1:0]     ofs_q;
    logic                 idle_drop;
    logic                 sop_err;
    logic                 ctx_we;
    logic [STATE_W-1:0]   ctx_wdata;
    logic [STATE_W-1:0]   ctx_rd;
    logic                 clr_hits_cur;

    dpi_ctx_ram #(
        .ADDR_W (FLOW_BITS),
        .DATA_W (STATE_W)
    ) u_ctx (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (cur_flow_q),
        .rd_data  (ctx_rd),
        .wr_en    (ctx_we),
        .wr_addr  (cur_flow_q),
        .wr_data  (ctx_wdata),
        .clr_en   (flow_clr),
        .clr_addr (flow_clr_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake; ready never looks at accept_in.
    always_comb begin
        state_d      = state_q;
        pkt_ready    = 1'b0;
        char_out_vld = 1'b0;
        idle_drop    = 1'b0;
        sop_err      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    if (pkt_sop) begin
                        state_d = LOAD;
                    end else begin
                        pkt_ready = 1'b1;
                        idle_drop = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (pkt_valid && pkt_sop && !first_q) begin
                    // Leave the new sop beat pending; it opens the next packet.
                    sop_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    pkt_ready = 1'b1;
                    if (pkt_valid) begin
                        char_out_vld = 1'b1;
                        if (pkt_eop) begin
                            state_d = SAVE;
                        end
                    end
                end
            end
            SAVE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign char_out       = pkt_data;
    assign state_load_vld = (state_q == LOAD);
    assign state_load     = (state_q == LOAD) ? ctx_rd : '0;
    assign ctx_we         = (state_q == SAVE);
    assign ctx_wdata      = pend_clr_q ? '0 : state_cur;
    assign clr_hits_cur   = flow_clr && (flow_clr_id == cur_flow_q);

    // Per-packet bookkeeping: flow, first-beat flag, offset, pending clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_flow_q <= '0;
            first_q    <= 1'b0;
            ofs_q      <= '0;
            pend_clr_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && pkt_valid && pkt_sop) begin
                cur_flow_q <= pkt_flow;
            end
            if (state_q == LOAD) begin
                first_q <= 1'b1;
                ofs_q   <= '0;
            end else if (char_out_vld) begin
                first_q <= 1'b0;
                if (ofs_q != OFS_MAX) begin
                    ofs_q <= ofs_q + OFS_W'(1);
                end
            end
            if (state_q == IDLE) begin
                pend_clr_q <= 1'b0;
            end else if (((state_q == LOAD) || (state_q == STREAM)) && clr_hits_cur) begin
                pend_clr_q <= 1'b1;
            end
        end
    end

    // Registered match report and framing-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_vld    <= 1'b0;
            match_flow   <= '0;
            match_offset <= '0;
            proto_err    <= 1'b0;
        end else begin
            match_vld <= char_out_vld && accept_in;
            proto_err <= idle_drop || sop_err;
            if (char_out_vld && accept_in) begin
                match_flow   <= cur_flow_q;
                match_offset <= ofs_q;
            end
        end
    end

endmodule

// File: tb/tb_dpi_flow_feeder.sv
// Directed bench for dpi_flow_feeder with a tiny "ABC" DFA standing in for the matcher.
module tb_dpi_flow_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_data;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [3:0]  pkt_flow;
    logic        flow_clr;
    logic [3:0]  flow_clr_id;
    logic [7:0]  char_out;
    logic        char_out_vld;
    logic [10:0] state_load;
    logic        state_load_vld;
    logic [10:0] state_cur;
    logic        accept_in;
    logic        match_vld;
    logic [3:0]  match_flow;
    logic [15:0] match_offset;
    logic        proto_err;

    int n_vec = 0;
    int n_err = 0;

    int          n_char;
    int          n_ready;
    int          n_perr;
    int          n_overlap = 0;
    logic [10:0] load_q[$];
    logic [3:0]  mflow_q[$];
    logic [15:0] mofs_q[$];

    logic [10:0] m_st;

    dpi_flow_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_data       (pkt_data),
        .pkt_sop        (pkt_sop),
        .pkt_eop        (pkt_eop),
        .pkt_flow       (pkt_flow),
        .flow_clr       (flow_clr),
        .flow_clr_id    (flow_clr_id),
        .char_out       (char_out),
        .char_out_vld   (char_out_vld),
        .state_load     (state_load),
        .state_load_vld (state_load_vld),
        .state_cur      (state_cur),
        .accept_in      (accept_in),
        .match_vld      (match_vld),
        .match_flow     (match_flow),
        .match_offset   (match_offset),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    // Matcher stand-in: state = {progress through "ABC", last byte}.
    function automatic logic [10:0] dfa_next(input logic [10:0] s, input logic [7:0] c);
        logic [2:0] k;
        if (c == 8'h41)                      k = 3'd1;
        else if (s[10:8] == 3'd1 && c == 8'h42) k = 3'd2;
        else if (s[10:8] == 3'd2 && c == 8'h43) k = 3'd3;
        else                                 k = 3'd0;
        return {k, c};
    endfunction

    always @(posedge clk) begin
        if (rst)                 m_st <= '0;
        else if (state_load_vld) m_st <= state_load;
        else if (char_out_vld)   m_st <= dfa_next(m_st, char_out);
    end
    assign state_cur = m_st;
    assign accept_in = char_out_vld && (m_st[10:8] == 3'd2) && (char_out == 8'h43);

    always @(negedge clk) begin
        if (state_load_vld) load_q.push_back(state_load);
        if (char_out_vld) n_char++;
        if (pkt_ready) n_ready++;
        if (proto_err) n_perr++;
        if (state_load_vld && char_out_vld) n_overlap++;
        if (match_vld) begin
            mflow_q.push_back(match_flow);
            mofs_q.push_back(match_offset);
        end
    end

    task automatic clear_mon();
        n_char = 0; n_ready = 0; n_perr = 0;
        load_q.delete(); mflow_q.delete(); mofs_q.delete();
    endtask

    task automatic send_beat(input logic [7:0] d, input bit sop, input bit eop,
                             input logic [3:0] fl, input bit clr);
        bit done = 1'b0;
        pkt_valid = 1'b1; pkt_data = d; pkt_sop = sop; pkt_eop = eop; pkt_flow = fl;
        flow_clr = clr; flow_clr_id = fl;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (pkt_ready) done = 1'b1;
            @(posedge clk); #1;
            flow_clr = 1'b0;
        end
        pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL handshake: pkt_ready actual 0 within 20 cycles, required 1");
        end
    endtask

    // Sends a whole packet; clr_at == len asserts flow_clr during the SAVE cycle.
    task automatic send_pkt(input logic [3:0] fl, input string s, input int clr_at);
        for (int i = 0; i < s.len(); i++) begin
            send_beat(s[i], i == 0, i == s.len() - 1, fl, i == clr_at);
        end
        if (clr_at == s.len()) begin
            flow_clr = 1'b1; flow_clr_id = fl;
        end
        @(posedge clk); #1;
        flow_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic probe(input logic [3:0] fl, output logic [10:0] v, output int cnt);
        load_q.delete();
        send_pkt(fl, "z", -1);
        cnt = load_q.size();
        v = (cnt > 0) ? load_q[0] : 11'h7FF;
    endtask

    task automatic test_reset();
        rst = 1'b1; pkt_valid = 0; pkt_data = 0; pkt_sop = 0; pkt_eop = 0;
        pkt_flow = 0; flow_clr = 0; flow_clr_id = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({pkt_ready, char_out_vld, state_load_vld, match_vld, proto_err} !== 5'b0 ||
            state_load !== 11'h0 || match_flow !== 4'h0 || match_offset !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b cvld=%b lvld=%b load=%h mvld=%b mflow=%h mofs=%h perr=%b, required all 0",
                     pkt_ready, char_out_vld, state_load_vld, state_load, match_vld, match_flow, match_offset, proto_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_pass_packet();
        logic [10:0] v; int c;
        clear_mon();
        send_pkt(4'd3, "PASS\n", -1);
        n_vec++;
        if (load_q.size() != 1 || load_q[0] !== 11'h000) begin
            n_err++; $display("FAIL pass_load: %0d loads first %h, required 1 load of 000", load_q.size(), (load_q.size() > 0) ? load_q[0] : 11'h7FF);
        end
        n_vec++;
        if (n_char != 5) begin n_err++; $display("FAIL pass_chars: actual %0d required 5", n_char); end
        n_vec++;
        if (mflow_q.size() != 0) begin n_err++; $display("FAIL pass_nomatch: actual %0d matches required 0", mflow_q.size()); end
        probe(4'd3, v, c);
        n_vec++;
        if (c != 1 || v !== 11'h00A) begin n_err++; $display("FAIL pass_ctx3: actual %h required 00a", v); end
    endtask

    task automatic test_split_pattern();
        logic [10:0] v; int c;
        send_pkt(4'd3, "xAB", -1);
        send_pkt(4'd5, "ZZ", -1);
        clear_mon();
        send_pkt(4'd3, "Cq", -1);
        n_vec++;
        if (load_q.size() != 1 || load_q[0] !== 11'h242) begin
            n_err++; $display("FAIL split_restore: actual %h required 242", (load_q.size() > 0) ? load_q[0] : 11'h7FF);
        end
        n_vec++;
        if (mflow_q.size() != 1 || mflow_q[0] !== 4'd3 || mofs_q[0] !== 16'd0) begin
            n_err++; $display("FAIL split_match: count %0d, required one match flow 3 offset 0", mflow_q.size());
        end
        clear_mon();
        send_pkt(4'd3, "zzABCz", -1);
        n_vec++;
        if (mflow_q.size() != 1 || mflow_q[0] !== 4'd3 || mofs_q[0] !== 16'd4) begin
            n_err++; $display("FAIL inpkt_match: count %0d, required one match flow 3 offset 4", mflow_q.size());
        end
        n_vec++;
        if (load_q.size() != 1 || load_q[0] !== 11'h071) begin
            n_err++; $display("FAIL b2b_restore: actual %h required 071", (load_q.size() > 0) ? load_q[0] : 11'h7FF);
        end
        probe(4'd5, v, c);
        n_vec++;
        if (c != 1 || v !== 11'h05A) begin n_err++; $display("FAIL split_ctx5: actual %h required 05a", v); end
    endtask

    task automatic test_single_beat();
        logic [10:0] v; int c;
        clear_mon();
        send_pkt(4'd7, "A", -1);
        n_vec++;
        if (n_ready != 1) begin n_err++; $display("FAIL single_ready: actual %0d cycles required 1", n_ready); end
        n_vec++;
        if (n_char != 1 || load_q.size() != 1) begin
            n_err++; $display("FAIL single_seq: chars %0d loads %0d, required 1 and 1", n_char, load_q.size());
        end
        probe(4'd7, v, c);
        n_vec++;
        if (c != 1 || v !== 11'h141) begin n_err++; $display("FAIL single_ctx7: actual %h required 141", v); end
    endtask

    task automatic test_flow_clr();
        logic [10:0] v; int c;
        send_pkt(4'd3, "AB", 2);
        probe(4'd3, v, c);
        n_vec++;
        if (c != 1 || v !== 11'h000) begin n_err++; $display("FAIL clr_vs_save: actual %h required 000", v); end
        clear_mon();
        send_pkt(4'd3, "AB", 1);
        n_vec++;
        if (load_q.size() != 1 || load_q[0] !== 11'h07A) begin
            n_err++; $display("FAIL clr_mid_load: actual %h required 07a", (load_q.size() > 0) ? load_q[0] : 11'h7FF);
        end
        probe(4'd3, v, c);
        n_vec++;
        if (c != 1 || v !== 11'h000) begin n_err++; $display("FAIL clr_mid_save: actual %h required 000", v); end
    endtask

    task automatic test_proto_err();
        logic [10:0] v; int c;
        clear_mon();
        send_beat(8'h41, 1'b1, 1'b0, 4'd2, 1'b0);
        send_beat(8'h42, 1'b0, 1'b0, 4'd2, 1'b0);
        send_beat(8'h78, 1'b1, 1'b1, 4'd4, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        n_vec++;
        if (n_perr != 1) begin n_err++; $display("FAIL sop_err_pulse: actual %0d pulses required 1", n_perr); end
        n_vec++;
        if (load_q.size() != 2 || n_char != 3) begin
            n_err++; $display("FAIL sop_err_reload: loads %0d chars %0d, required 2 and 3", load_q.size(), n_char);
        end
        probe(4'd2, v, c);
        n_vec++;
        if (c != 1 || v !== 11'h000) begin n_err++; $display("FAIL sop_err_ctx2: actual %h required 000", v); end
        probe(4'd4, v, c);
        n_vec++;
        if (c != 1 || v !== 11'h078) begin n_err++; $display("FAIL sop_err_ctx4: actual %h required 078", v); end
        clear_mon();
        send_beat(8'h41, 1'b0, 1'b0, 4'd0, 1'b0);
        @(posedge clk); #1;
        n_vec++;
        if (n_perr != 1 || n_char != 0 || load_q.size() != 0) begin
            n_err++; $display("FAIL idle_drop: perr %0d chars %0d loads %0d, required 1 0 0", n_perr, n_char, load_q.size());
        end
    endtask

    task automatic test_rst_mid_stream();
        logic [10:0] v; int c;
        send_beat(8'h41, 1'b1, 1'b0, 4'd6, 1'b0);
        send_beat(8'h42, 1'b0, 1'b0, 4'd6, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({pkt_ready, char_out_vld, state_load_vld, match_vld, proto_err} !== 5'b0 ||
            state_load !== 11'h0 || match_flow !== 4'h0 || match_offset !== 16'h0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: ready=%b cvld=%b lvld=%b load=%h mvld=%b mflow=%h mofs=%h perr=%b, required all 0",
                     pkt_ready, char_out_vld, state_load_vld, state_load, match_vld, match_flow, match_offset, proto_err);
        end
        @(posedge clk); #1;
        for (int f = 0; f < 16; f++) begin
            probe(4'(f), v, c);
            n_vec++;
            if (c != 1 || v !== 11'h000) begin n_err++; $display("FAIL rst_ctx%0d: actual %h required 000", f, v); end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] b;
        clear_mon();
        for (int i = 0; i < 70000; i++) begin
            b = 8'h7A;
            if (i == 1000 || i == 65533 || i == 69997) b = 8'h41;
            if (i == 1001 || i == 65534 || i == 69998) b = 8'h42;
            if (i == 1002 || i == 65535 || i == 69999) b = 8'h43;
            send_beat(b, i == 0, i == 69999, 4'd1, 1'b0);
        end
        repeat (2) begin @(posedge clk); #1; end
        n_vec++;
        if (mofs_q.size() != 3) begin
            n_err++; $display("FAIL sat_count: actual %0d matches required 3", mofs_q.size());
        end else begin
            n_vec++;
            if (mofs_q[0] !== 16'd1002 || mflow_q[0] !== 4'd1) begin
                n_err++; $display("FAIL sat_mid: actual ofs %0d flow %0d required 1002 flow 1", mofs_q[0], mflow_q[0]);
            end
            n_vec++;
            if (mofs_q[1] !== 16'hFFFF) begin n_err++; $display("FAIL sat_edge: actual %h required ffff", mofs_q[1]); end
            n_vec++;
            if (mofs_q[2] !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: actual %h required ffff", mofs_q[2]); end
        end
        n_vec++;
        if (n_overlap != 0) begin n_err++; $display("FAIL load_char_overlap: actual %0d cycles required 0", n_overlap); end
    endtask

    initial begin
        test_reset();
        test_pass_packet();
        test_split_pattern();
        test_single_beat();
        test_flow_clr();
        test_proto_err();
        test_rst_mid_stream();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dpi_flow_feeder.md
# dpi_flow_feeder

Per-flow driver for one DFA regex matcher in the DPI pipeline. It accepts byte-wide packet beats tagged with a flow ID and restores that flow's saved DFA state into the matcher before the first byte. It then streams the payload bytes into the matcher and saves the matcher's final state back into a per-flow context table at end of packet. Matches are reported with flow ID and byte offset. It sits between the packet parser and a matcher instance, and is the state-load/state-save end of the matcher's `state_in`/`state_out` interface.

## Interface
Parameters:
- FLOW_BITS, 4, flow ID width (2^FLOW_BITS context entries)
- STATE_W, 11, DFA state width (matches matcher `state_in`/`state_out`)
- OFS_W, 16, match byte-offset width

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- pkt_valid  in  1  input beat valid
- pkt_ready  out  1  input beat accepted when valid&ready
- pkt_data  in  8  payload byte
- pkt_sop  in  1  first beat of packet
- pkt_eop  in  1  last beat of packet (may coincide with sop)
- pkt_flow  in  FLOW_BITS  flow ID, sampled on sop beat only
- flow_clr  in  1  one-cycle request to zero a context entry
- flow_clr_id  in  FLOW_BITS  entry to clear
- char_out  out  8  to matcher `char_in` (= pkt_data)
- char_out_vld  out  1  to matcher `char_in_vld`
- state_load  out  STATE_W  to matcher `state_in`
- state_load_vld  out  1  to matcher `state_in_vld`
- state_cur  in  STATE_W  from matcher `state_out`
- accept_in  in  1  from matcher `accept_out` (combinational)
- match_vld  out  1  registered one-cycle match pulse
- match_flow  out  FLOW_BITS  flow of reported match
- match_offset  out  OFS_W  0-based byte offset of accepting byte in packet
- proto_err  out  1  one-cycle pulse on framing error

## Operation
- FSM states: IDLE, LOAD, STREAM, SAVE.
- IDLE: pkt_ready=0. On pkt_valid&pkt_sop, register pkt_flow -> cur_flow and go to LOAD. Non-sop valid beats in IDLE are dropped (ready pulses 1 for that beat), with a proto_err pulse.
- LOAD (1 cycle): state_load_vld=1, state_load=ctx[cur_flow]. Clear offset counter; go to STREAM.
- STREAM: pkt_ready=1 except when a non-first beat carries pkt_sop (see errors). char_out_vld = pkt_valid&pkt_ready; char_out = pkt_data. Offset counter increments per accepted beat and saturates at 2^OFS_W-1. When char_out_vld&accept_in: match_vld<=1, match_flow<=cur_flow, match_offset<=current offset. Accepted beat with eop -> SAVE.
- SAVE (1 cycle): ctx[cur_flow] <= state_cur (the matcher's post-eop state); go to IDLE.
- flow_clr: ctx[flow_clr_id] <= 0 next edge. If it collides with a SAVE to the same entry in the same cycle, clear wins. A clear to cur_flow during LOAD/STREAM sets a pending flag so SAVE writes 0.
- Errors: a sop beat in STREAM after the first beat is not accepted (ready=0). Current packet is abandoned: no SAVE, ctx unchanged, proto_err pulses, FSM -> IDLE, and that beat starts the next packet.
- Reset: FSM IDLE, all ctx entries 0, pending flag 0.

## Timing
- Reset values: pkt_ready 0, char_out_vld 0, state_load_vld 0, state_load 0, match_vld 0, match_flow 0, match_offset 0, proto_err 0.
- Sop beat presented in IDLE at cycle t: LOAD at t+1, sop byte accepted at t+2 at the earliest.
- Match reported one cycle after the accepting byte's edge.
- Eop accepted at cycle n: SAVE at n+1, IDLE at n+2, next LOAD no earlier than n+3. A same-flow back-to-back packet reads the just-saved state.
- pkt_ready depends combinationally on state, pkt_valid, pkt_sop and first-beat flag only. It is never a function of accept_in.
- state_load_vld and char_out_vld are never high together.

## Structure
- dpi_pkg: STATE_W default, feeder FSM enum (IDLE/LOAD/STREAM/SAVE), flow ID type.
- Sub-module dpi_ctx_ram: 2^FLOW_BITS x STATE_W register file. It has 1 async read port, 1 write port and a clear port with clear-wins priority, and resets synchronously to zero.

## Test plan
- Flow 3, packet "PASS\n" as one packet, ctx=0: matcher loaded with state 0, 5 char_out_vld cycles, ctx[3] = matcher final state after SAVE.
- Pattern split across two packets of flow 3, with a flow-5 packet in between: state is restored after the gap, match_vld at the accepting byte with match_flow=3 and the correct match_offset in the second packet; ctx[5] is unaffected.
- Single-beat packet (sop=eop): LOAD, 1 byte, SAVE; pkt_ready high for exactly one cycle.
- flow_clr of flow 3 in the same cycle as SAVE of flow 3: ctx[3]=0 afterward. flow_clr of flow 3 mid-packet: SAVE writes 0.
- Sop on the 3rd beat of a packet: proto_err pulses once, ctx unchanged, new packet's LOAD follows. Non-sop beat in IDLE: proto_err, beat dropped.
- rst asserted mid-STREAM: next cycle all outputs at reset values, all ctx entries 0. A 70000-byte packet: match_offset saturates at 0xFFFF.
